// File: rtl/long_inst_commit_arb.sv
// Commit arbiter for the long-latency units: one holding buffer per source,
// drained round-robin into a single registered register-file write and commit pulse.

module long_inst_commit_buf #(
   parameter int AW = 5,
   parameter int DW = 32,
   parameter int IW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_i,
   input  logic          grant_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] data_i,
   input  logic [IW-1:0] id_i,
   output logic          ready_o,
   output logic          valid_o,
   output logic          we_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] data_o,
   output logic [IW-1:0] id_o
);
   logic          valid_q, valid_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic [IW-1:0] id_q, id_d;
   logic          take;

   // A granted buffer is emptied this cycle, so it may accept a new result at once.
   assign ready_o = !valid_q || grant_i;
   assign take    = valid_i && ready_o;

   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      id_d    = id_q;
      if (take) begin
         valid_d = 1'b1;
         we_d    = we_i;
         addr_d  = addr_i;
         data_d  = data_i;
         id_d    = id_i;
      end else if (grant_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         id_q    <= '0;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         id_q    <= id_d;
      end
   end

   assign valid_o = valid_q;
   assign we_o    = we_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;
   assign id_o    = id_q;
endmodule

module long_inst_commit_arb #(
   parameter int NUM_SRC         = 4,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int DATA_WIDTH      = 32,
   parameter int COMMIT_ID_WIDTH = 3
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_SRC-1:0]                     src_valid_i,
   output logic [NUM_SRC-1:0]                     src_ready_o,
   input  logic [NUM_SRC-1:0]                     src_rd_we_i,
   input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]      src_rd_addr_i,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]          src_rd_data_i,
   input  logic [NUM_SRC*COMMIT_ID_WIDTH-1:0]     src_commit_id_i,
   output logic                                   reg_we_o,
   output logic [REG_ADDR_WIDTH-1:0]              reg_waddr_o,
   output logic [DATA_WIDTH-1:0]                  reg_wdata_o,
   output logic                                   commit_valid_o,
   output logic [COMMIT_ID_WIDTH-1:0]             commit_id_o,
   output logic                                   busy_o
);
   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0]                      buf_valid, buf_we, grant;
   logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0]  buf_addr;
   logic [NUM_SRC-1:0][DATA_WIDTH-1:0]      buf_data;
   logic [NUM_SRC-1:0][COMMIT_ID_WIDTH-1:0] buf_id;

   logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d, gidx, idx_w;
   logic                       any_grant;
   int                         idx;
   logic                       commit_valid_q, commit_valid_d;
   logic                       reg_we_q, reg_we_d;
   logic [REG_ADDR_WIDTH-1:0]  reg_waddr_q, reg_waddr_d;
   logic [DATA_WIDTH-1:0]      reg_wdata_q, reg_wdata_d;
   logic [COMMIT_ID_WIDTH-1:0] commit_id_q, commit_id_d;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      long_inst_commit_buf #(
         .AW(REG_ADDR_WIDTH), .DW(DATA_WIDTH), .IW(COMMIT_ID_WIDTH)
      ) u_buf (
         .clk     (clk),
         .rst_n   (rst_n),
         .valid_i (src_valid_i[i]),
         .grant_i (grant[i]),
         .we_i    (src_rd_we_i[i]),
         .addr_i  (src_rd_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
         .data_i  (src_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH]),
         .id_i    (src_commit_id_i[i*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH]),
         .ready_o (src_ready_o[i]),
         .valid_o (buf_valid[i]),
         .we_o    (buf_we[i]),
         .addr_o  (buf_addr[i]),
         .data_o  (buf_data[i]),
         .id_o    (buf_id[i])
      );
   end

   // First valid buffer at or after rr_ptr, wrapping.
   always_comb begin
      grant     = '0;
      gidx      = '0;
      any_grant = 1'b0;
      idx       = 0;
      idx_w     = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         idx_w = PTR_W'(idx);
         if (!any_grant && buf_valid[idx_w]) begin
            any_grant    = 1'b1;
            grant[idx_w] = 1'b1;
            gidx         = idx_w;
         end
      end
   end

   always_comb begin
      rr_ptr_d       = rr_ptr_q;
      commit_valid_d = any_grant;
      commit_id_d    = commit_id_q;
      reg_waddr_d    = reg_waddr_q;
      reg_wdata_d    = reg_wdata_q;
      reg_we_d       = 1'b0;
      if (any_grant) begin
         rr_ptr_d    = (int'(gidx) == NUM_SRC - 1) ? '0 : gidx + PTR_W'(1);
         commit_id_d = buf_id[gidx];
         reg_waddr_d = buf_addr[gidx];
         reg_wdata_d = buf_data[gidx];
         // x0 is never written, but the commit still retires the ID.
         reg_we_d    = buf_we[gidx] && (buf_addr[gidx] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q       <= '0;
         commit_valid_q <= 1'b0;
         commit_id_q    <= '0;
         reg_we_q       <= 1'b0;
         reg_waddr_q    <= '0;
         reg_wdata_q    <= '0;
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         commit_valid_q <= commit_valid_d;
         commit_id_q    <= commit_id_d;
         reg_we_q       <= reg_we_d;
         reg_waddr_q    <= reg_waddr_d;
         reg_wdata_q    <= reg_wdata_d;
      end
   end

   assign commit_valid_o = commit_valid_q;
   assign commit_id_o    = commit_id_q;
   assign reg_we_o       = reg_we_q;
   assign reg_waddr_o    = reg_waddr_q;
   assign reg_wdata_o    = reg_wdata_q;
   assign busy_o         = (|buf_valid) || commit_valid_q;
endmodule

// File: tb/tb_long_inst_commit_arb.sv
// Bench for long_inst_commit_arb: directed vector table, hand sequences for
// contention/backpressure/reset, then random traffic against a reference model.

module tb_long_inst_commit_arb;
   logic         clk;
   logic         rst_n;
   logic [3:0]   src_valid, src_ready, src_we;
   logic [19:0]  src_addr;
   logic [127:0] src_data;
   logic [11:0]  src_id;
   logic         reg_we, commit_valid, busy;
   logic [4:0]   reg_waddr;
   logic [31:0]  reg_wdata;
   logic [2:0]   commit_id;

   int checks = 0;
   int errors = 0;

   long_inst_commit_arb #(
      .NUM_SRC(4), .REG_ADDR_WIDTH(5), .DATA_WIDTH(32), .COMMIT_ID_WIDTH(3)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .src_valid_i     (src_valid),
      .src_ready_o     (src_ready),
      .src_rd_we_i     (src_we),
      .src_rd_addr_i   (src_addr),
      .src_rd_data_i   (src_data),
      .src_commit_id_i (src_id),
      .reg_we_o        (reg_we),
      .reg_waddr_o     (reg_waddr),
      .reg_wdata_o     (reg_wdata),
      .commit_valid_o  (commit_valid),
      .commit_id_o     (commit_id),
      .busy_o          (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout act=running req=finished");
      $fatal(1, "timeout");
   end

   // Two valid buffers must never hold the same commit ID.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
               if (dut.buf_valid[i] && dut.buf_valid[j] && dut.buf_id[i] == dut.buf_id[j]) begin
                  errors++;
                  $display("FAIL dup_id src%0d/src%0d act=%0d req=distinct", i, j, dut.buf_id[i]);
               end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h req=%h", nm, act, exp);
      end
   endtask

   task automatic set_src(input int i, input bit v, input bit we, input logic [4:0] a,
                          input logic [31:0] d, input logic [2:0] id);
      src_valid[i]      = v;
      src_we[i]         = we;
      src_addr[i*5 +: 5]  = a;
      src_data[i*32 +: 32] = d;
      src_id[i*3 +: 3]    = id;
   endtask

   typedef struct {
      int          src;
      bit          we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [2:0]  id;
      bit          exp_we;
   } vec_t;

   vec_t tbl[4];

   // Reference model state
   bit          m_bv[4];
   bit          m_we[4];
   logic [4:0]  m_addr[4];
   logic [31:0] m_data[4];
   logic [2:0]  m_id[4];
   int          m_ptr;
   bit          m_cv, m_rwe;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic [2:0]  m_cid;

   initial begin
      int          a_cnt, d_cnt, g;
      bit          saw_bp, hs0, hs2;
      bit          hs[4];
      bit          exp_rdy[4];
      logic [3:0]  exp_rdy_v;
      logic [2:0]  exp_seq[6];
      logic [2:0]  got[$];

      tbl[0] = '{src:0, we:1'b1, addr:5'd5,  data:32'hDEADBEEF, id:3'd3, exp_we:1'b1};
      tbl[1] = '{src:1, we:1'b1, addr:5'd0,  data:32'h12345678, id:3'd1, exp_we:1'b0};
      tbl[2] = '{src:2, we:1'b1, addr:5'd31, data:32'hFFFFFFFF, id:3'd7, exp_we:1'b1};
      tbl[3] = '{src:3, we:1'b0, addr:5'd7,  data:32'hCAFEF00D, id:3'd2, exp_we:1'b0};

      rst_n = 1'b0;
      src_valid = '0; src_we = '0; src_addr = '0; src_data = '0; src_id = '0;
      #2;
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_reg_we", reg_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", src_ready, 4'hF);
      chk("rst_waddr", reg_waddr, 0);
      chk("rst_wdata", reg_wdata, 0);
      chk("rst_commit_id", commit_id, 0);
      #20 rst_n = 1'b1;

      // Single results; sources in order 0..3 so rr_ptr wraps back to 0.
      for (int v = 0; v < 4; v++) begin
         @(posedge clk); #1;
         set_src(tbl[v].src, 1'b1, tbl[v].we, tbl[v].addr, tbl[v].data, tbl[v].id);
         @(posedge clk); #1;
         src_valid = '0;
         @(negedge clk);
         chk($sformatf("vec%0d_t1_commit_valid", v), commit_valid, 0);
         @(negedge clk);
         chk($sformatf("vec%0d_commit_valid", v), commit_valid, 1);
         chk($sformatf("vec%0d_commit_id", v), commit_id, tbl[v].id);
         chk($sformatf("vec%0d_reg_we", v), reg_we, tbl[v].exp_we);
         chk($sformatf("vec%0d_waddr", v), reg_waddr, tbl[v].addr);
         chk($sformatf("vec%0d_wdata", v), reg_wdata, tbl[v].data);
         @(negedge clk);
         chk($sformatf("vec%0d_after_commit_valid", v), commit_valid, 0);
         chk($sformatf("vec%0d_after_reg_we", v), reg_we, 0);
         chk($sformatf("vec%0d_hold_waddr", v), reg_waddr, tbl[v].addr);
      end

      // All four at once: commit in source order, one per cycle.
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) set_src(i, 1'b1, 1'b1, 5'(10 + i), 32'h1000 + i, 3'(i));
      @(posedge clk); #1;
      src_valid = '0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("all4_c%0d_valid", k), commit_valid, 1);
         chk($sformatf("all4_c%0d_id", k), commit_id, k);
         chk($sformatf("all4_c%0d_waddr", k), reg_waddr, 10 + k);
         chk($sformatf("all4_c%0d_busy", k), busy, 1);
      end
      @(negedge clk);
      chk("all4_end_valid", commit_valid, 0);
      chk("all4_end_busy", busy, 0);
      chk("all4_end_rr_ptr", dut.rr_ptr_q, 0);

      // ALU and DIV stream 3 results each; expect alternation A,D,A,D,A,D.
      a_cnt = 0; d_cnt = 0; saw_bp = 0;
      exp_seq = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6};
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         set_src(0, a_cnt < 3, 1'b1, 5'(1 + a_cnt), 32'hA000 + a_cnt, 3'(a_cnt));
         set_src(2, d_cnt < 3, 1'b1, 5'(20 + d_cnt), 32'hD000 + d_cnt, 3'(4 + d_cnt));
         @(negedge clk);
         if (commit_valid) got.push_back(commit_id);
         hs0 = src_valid[0] && src_ready[0];
         hs2 = src_valid[2] && src_ready[2];
         if (src_valid[2] && !src_ready[2]) saw_bp = 1;
         @(posedge clk); #1;
         if (hs0) a_cnt++;
         if (hs2) d_cnt++;
      end
      src_valid = '0;
      chk("bp_div_ready_dropped", saw_bp, 1);
      chk("bp_alu_sent", a_cnt, 3);
      chk("bp_div_sent", d_cnt, 3);
      chk("bp_commit_count", got.size(), 6);
      for (int k = 0; k < 6; k++)
         if (k < got.size()) chk($sformatf("bp_order%0d", k), got[k], exp_seq[k]);

      // Reset while two buffers are valid and a commit is on the outputs.
      @(posedge clk); #1;
      set_src(0, 1'b1, 1'b1, 5'd3, 32'h11, 3'd1);
      set_src(1, 1'b1, 1'b1, 5'd4, 32'h22, 3'd2);
      set_src(2, 1'b1, 1'b1, 5'd6, 32'h33, 3'd3);
      @(posedge clk); #1;
      src_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_pre_commit_valid", commit_valid, 1);
      chk("mid_pre_bufs", $countones(dut.buf_valid), 2);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_commit_valid", commit_valid, 0);
      chk("mid_rst_reg_we", reg_we, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", src_ready, 4'hF);
      chk("mid_rst_commit_id", commit_id, 0);
      chk("mid_rst_waddr", reg_waddr, 0);
      chk("mid_rst_wdata", reg_wdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d_commit_valid", k), commit_valid, 0);
         chk($sformatf("post_rst%0d_busy", k), busy, 0);
      end

      // Random traffic against the model; DUT is in its reset state here.
      for (int i = 0; i < 4; i++) begin
         m_bv[i] = 0; m_we[i] = 0; m_addr[i] = '0; m_data[i] = '0; m_id[i] = '0;
      end
      m_ptr = 0; m_cv = 0; m_rwe = 0; m_waddr = '0; m_wdata = '0; m_cid = '0;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
         set_src(i, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom, 3'(i + 4 * $urandom_range(0, 1)));
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         g = -1;
         for (int k = 0; k < 4; k++)
            if (g < 0 && m_bv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
         for (int i = 0; i < 4; i++) begin
            exp_rdy[i]   = !m_bv[i] || (g == i);
            exp_rdy_v[i] = exp_rdy[i];
         end
         chk("rnd_ready", src_ready, exp_rdy_v);
         chk("rnd_commit_valid", commit_valid, m_cv);
         chk("rnd_reg_we", reg_we, m_rwe);
         chk("rnd_commit_id", commit_id, m_cid);
         chk("rnd_waddr", reg_waddr, m_waddr);
         chk("rnd_wdata", reg_wdata, m_wdata);
         chk("rnd_busy", busy, m_bv[0] | m_bv[1] | m_bv[2] | m_bv[3] | m_cv);
         // Outputs from the old buffer contents, then buffer updates.
         m_cv  = (g >= 0);
         m_rwe = 0;
         if (g >= 0) begin
            m_cid   = m_id[g];
            m_waddr = m_addr[g];
            m_wdata = m_data[g];
            m_rwe   = m_we[g] && (m_addr[g] != 0);
            m_ptr   = (g + 1) % 4;
         end
         for (int i = 0; i < 4; i++) begin
            hs[i] = src_valid[i] && src_ready[i];
            if (src_valid[i] && exp_rdy[i]) begin
               m_bv[i]   = 1;
               m_we[i]   = src_we[i];
               m_addr[i] = src_addr[i*5 +: 5];
               m_data[i] = src_data[i*32 +: 32];
               m_id[i]   = src_id[i*3 +: 3];
            end else if (g == i) begin
               m_bv[i] = 0;
            end
         end
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++)
            if (!src_valid[i] || hs[i])
               set_src(i, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                       $urandom, 3'(i + 4 * $urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/long_inst_commit_arb.md
# long_inst_commit_arb

Collects completion results from the long-instruction execution units (ALU, MUL, DIV, CSR) and serialises them into one register-file write and one commit per cycle. Its commit_valid_o/commit_id_o outputs drive the hazard unit's commit_valid_i/commit_id_i, which frees the matching scoreboard entry. Each source has a one-entry holding buffer, and a round-robin arbiter drains the buffers, so a unit can retire while another source is being committed.

## Interface
- NUM_SRC, 4: number of completing units; index 0=ALU, 1=MUL, 2=DIV, 3=CSR.
- REG_ADDR_WIDTH, 5: register address width.
- DATA_WIDTH, 32: write-back data width.
- COMMIT_ID_WIDTH, 3: commit ID width; matches the hazard unit's ID space.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- src_valid_i  in  NUM_SRC  per-source result valid.
- src_ready_o  out  NUM_SRC  per-source ready; the transfer occurs when valid&ready.
- src_rd_we_i  in  NUM_SRC  per-source "writes rd" flag.
- src_rd_addr_i  in  NUM_SRC*REG_ADDR_WIDTH  packed; source i occupies slice [i*W +: W].
- src_rd_data_i  in  NUM_SRC*DATA_WIDTH  packed, same slicing rule.
- src_commit_id_i  in  NUM_SRC*COMMIT_ID_WIDTH  ID the hazard unit assigned at issue.
- reg_we_o  out  1  register-file write enable.
- reg_waddr_o  out  REG_ADDR_WIDTH  write address.
- reg_wdata_o  out  DATA_WIDTH  write data.
- commit_valid_o  out  1  one-cycle commit pulse to the hazard unit.
- commit_id_o  out  COMMIT_ID_WIDTH  ID being retired.
- busy_o  out  1  asserted when any buffer is valid or commit_valid_o is high.

## Operation
- Per-source buffer
  - Holds buf_valid[i], we, addr, data and id.
  - src_ready_o[i] = !buf_valid[i] || grant[i]. This is combinational, so a drained buffer refills in the same cycle.
  - On valid&ready the buffer captures the source fields and sets buf_valid[i].
  - On grant without a new capture, buf_valid[i] clears.
- Arbiter
  - Uses the round-robin pointer rr_ptr (log2 NUM_SRC bits).
  - grant is one-hot: the first i with buf_valid[i], searching from rr_ptr upward and wrapping modulo NUM_SRC.
  - No grant when all buffers are empty.
  - After a grant to i, rr_ptr <= (i+1) mod NUM_SRC. rr_ptr holds when there is no grant.
- Output register, updated every cycle
  - commit_valid_o <= |grant.
  - commit_id_o, reg_waddr_o and reg_wdata_o <= the granted buffer's fields. When there is no grant, they hold their previous values.
  - reg_we_o <= |grant && granted.we && granted.addr != 0.
  - x0 writes are suppressed, but the commit still pulses.
  - A result with rd_we=0 still produces commit_valid_o; reg_we_o stays 0.
- No ID checking or reordering. Sources own ID uniqueness. A bench assertion flags two valid buffers holding the same ID.

## Timing
- Reset values:
  - All buf_valid = 0 and rr_ptr = 0.
  - commit_valid_o, reg_we_o, busy_o = 0.
  - commit_id_o, reg_waddr_o, reg_wdata_o = 0.
  - src_ready_o = all ones.
- Latency: a handshake in cycle T gives buffer valid in T+1; if it is granted in T+1, commit_valid_o/reg_we_o are high in T+2 for exactly one cycle. Minimum latency is 2 cycles.
- Throughput:
  - One commit per cycle aggregate.
  - A single source streaming back-to-back achieves one result per cycle, because ready stays high while its buffer is granted each cycle.
- Contention: with N buffers valid, each is granted within N cycles. No source starves.
- Simultaneous capture and grant on the same source: the new data is captured, buf_valid stays 1, and the old data goes to the output.
- Backpressure: a source whose buffer is full and not granted sees ready=0 and must hold valid and its fields stable.
- Asynchronous reset mid-operation drops all buffered results and any in-flight commit. The hazard unit is reset by the same rst_n.

## Test plan
- Single ALU result: valid in cycle 1 with rd_we=1, addr=5, data=0xDEADBEEF, id=3.
  - Required: cycle 3 has commit_valid_o=1, commit_id_o=3, reg_we_o=1, reg_waddr_o=5, reg_wdata_o=0xDEADBEEF.
  - Required: cycle 4 has commit_valid_o=0.
- All four sources valid in the same cycle with ids 0-3, rr_ptr=0.
  - Required: commits in cycles +2..+5 in id order 0,1,2,3.
  - Required: rr_ptr=0 afterwards; busy_o falls after the last commit.
- x0 and no-write cases.
  - MUL with addr=0, rd_we=1: commit_valid_o=1 and reg_we_o=0.
  - CSR with rd_we=0, addr=7: commit_valid_o=1 and reg_we_o=0.
- Backpressure: DIV streams 3 results back-to-back while ALU is also streaming.
  - Required: DIV ready drops to 0 while its buffer waits, and no result is lost or duplicated.
  - Required: commits alternate between sources, and the total equals the number of results sent.
- Reset mid-stream: assert rst_n=0 while 2 buffers are valid and commit_valid_o=1.
  - Required: all outputs are 0 immediately and src_ready_o=4'b1111.
  - Required: no commit after release until new inputs arrive.
